// File: rtl/soc_sram_arb_pkg.sv
// Shared types and helpers for the
// single-port SRAM Wishbone arbiter.
package soc_sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } sram_arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  // Next word address of a burst; wrap
  // bursts only advance the low bits.
  function automatic logic [63:0] burst_next_addr(
    input logic [63:0] addr,
    input logic [1:0]  bte
  );
    logic [63:0] inc;
    logic [63:0] res;
    inc = addr + 64'd1;
    case (bte)
      BTE_WRAP4:  res = {addr[63:2], inc[1:0]};
      BTE_WRAP8:  res = {addr[63:3], inc[2:0]};
      BTE_WRAP16: res = {addr[63:4], inc[3:0]};
      default:    res = inc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/soc_sram_rr_arbiter.sv
// Round-robin request picker: first
// requester at or after rr_last+1.
module soc_sram_rr_arbiter #(
  parameter int PORTS = 2,
  localparam int IW = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IW-1:0]    rr_last_i,
  output logic [PORTS-1:0] gnt_oh_o,
  output logic [IW-1:0]    gnt_idx_o
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan ports in rotating priority order.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    cand      = '0;
    found     = 1'b0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      cand = IW'((32'(rr_last_i) + i) % 32'(PORTS));
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        gnt_oh_o[cand] = 1'b1;
        gnt_idx_o      = cand;
      end
    end
  end

endmodule

// File: rtl/soc_sram_sp_arbiter.sv
// Wishbone B3 multi-port front end for one
// single-port 1-cycle-latency SRAM macro.
module soc_sram_sp_arbiter
  import soc_sram_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_SIZE_BYTE = 32768,
  parameter int PORTS = 2,
  localparam int SW = DW / 8,
  localparam int WORD_AW = AW - (SW >> 1),
  localparam int MEM_SIZE_WORDS = MEM_SIZE_BYTE / SW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0][AW-1:0]     wb_adr_i,
  input  logic [PORTS-1:0][DW-1:0]     wb_dat_i,
  input  logic [PORTS-1:0][SW-1:0]     wb_sel_i,
  input  logic [PORTS-1:0]             wb_we_i,
  input  logic [PORTS-1:0]             wb_cyc_i,
  input  logic [PORTS-1:0]             wb_stb_i,
  input  logic [PORTS-1:0][2:0]        wb_cti_i,
  input  logic [PORTS-1:0][1:0]        wb_bte_i,
  output logic [PORTS-1:0][DW-1:0]     wb_dat_o,
  output logic [PORTS-1:0]             wb_ack_o,
  output logic [PORTS-1:0]             wb_err_o,
  output logic                         sram_ce,
  output logic                         sram_we,
  output logic                         sram_oe,
  output logic [WORD_AW-1:0]           sram_waddr,
  output logic [DW-1:0]                sram_din,
  output logic [SW-1:0]                sram_sel,
  input  logic [DW-1:0]                sram_dout
);

  localparam int OFF = $clog2(SW);
  localparam int IW  = $clog2(PORTS);

  sram_arb_state_t state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   rr_last_q, rr_last_d;
  logic            burst_q, burst_d;
  logic            err_q, err_d;
  logic [WORD_AW-1:0] baddr_q, baddr_d;

  logic [PORTS-1:0] req;
  logic [PORTS-1:0] arb_oh;
  logic [IW-1:0]    arb_idx;

  logic               g_cyc, g_stb, g_we;
  logic [2:0]         g_cti;
  logic [1:0]         g_bte;
  logic [AW-1:0]      g_adr;
  logic [DW-1:0]      g_dat;
  logic [SW-1:0]      g_sel;
  logic [WORD_AW-1:0] g_word, nxt_word;
  logic               g_ok, nxt_ok;

  assign req   = wb_cyc_i & wb_stb_i;
  assign g_cyc = wb_cyc_i[grant_q];
  assign g_stb = wb_stb_i[grant_q];
  assign g_we  = wb_we_i[grant_q];
  assign g_cti = wb_cti_i[grant_q];
  assign g_bte = wb_bte_i[grant_q];
  assign g_adr = wb_adr_i[grant_q];
  assign g_dat = wb_dat_i[grant_q];
  assign g_sel = wb_sel_i[grant_q];

  assign g_word   = WORD_AW'(g_adr >> OFF);
  assign nxt_word = WORD_AW'(burst_next_addr(64'(baddr_q), g_bte));
  assign g_ok     = AW'(g_word) < AW'(MEM_SIZE_WORDS);
  assign nxt_ok   = AW'(nxt_word) < AW'(MEM_SIZE_WORDS);

  assign wb_dat_o = {PORTS{sram_dout}};

  soc_sram_rr_arbiter #(
    .PORTS(PORTS)
  ) u_arb (
    .req_i     (req),
    .rr_last_i (rr_last_q),
    .gnt_oh_o  (arb_oh),
    .gnt_idx_o (arb_idx)
  );

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      rr_last_q <= IW'(PORTS - 1);
      burst_q   <= 1'b0;
      err_q     <= 1'b0;
      baddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      baddr_q   <= baddr_d;
    end
  end

  // Next state, SRAM strobes and bus termination.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    burst_d    = burst_q;
    err_d      = err_q;
    baddr_d    = baddr_q;
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_oe    = 1'b0;
    sram_waddr = '0;
    sram_din   = '0;
    sram_sel   = '0;
    wb_ack_o   = '0;
    wb_err_o   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_oh) begin
          grant_d = arb_idx;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!g_cyc) begin
          state_d   = ST_IDLE;
          rr_last_d = grant_q;
        end else if (g_stb) begin
          if (g_ok) begin
            sram_ce    = 1'b1;
            sram_we    = g_we;
            sram_oe    = !g_we;
            sram_waddr = g_word;
            sram_din   = g_dat;
            sram_sel   = g_sel;
          end
          err_d   = !g_ok;
          burst_d = !g_we && (g_cti == CTI_INCR);
          baddr_d = g_word;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        wb_ack_o[grant_q] = !err_q;
        wb_err_o[grant_q] = err_q;
        if (burst_q && g_cyc && g_stb && (g_cti != CTI_EOB)) begin
          if (nxt_ok) begin
            sram_ce    = 1'b1;
            sram_oe    = 1'b1;
            sram_waddr = nxt_word;
            sram_sel   = g_sel;
          end
          baddr_d = nxt_word;
          err_d   = !nxt_ok;
        end else if (g_cyc) begin
          state_d = ST_ADDR;
        end else begin
          state_d   = ST_IDLE;
          rr_last_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_soc_sram_sp_arbiter.sv
// Directed self-checking bench for the
// single-port SRAM Wishbone arbiter.
module tb_soc_sram_sp_arbiter;
  import soc_sram_arb_pkg::*;

  localparam int P = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [P-1:0][31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [P-1:0][3:0]  wb_sel_i;
  logic [P-1:0]       wb_we_i, wb_cyc_i, wb_stb_i;
  logic [P-1:0]       wb_ack_o, wb_err_o;
  logic [P-1:0][2:0]  wb_cti_i;
  logic [P-1:0][1:0]  wb_bte_i;
  logic               sram_ce, sram_we, sram_oe;
  logic [29:0]        sram_waddr;
  logic [31:0]        sram_din, sram_dout;
  logic [3:0]         sram_sel;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:8191];
  logic        c_ce = 1'b0, c_we = 1'b0, c_oe = 1'b0;
  logic [12:0] c_addr;
  logic [31:0] c_din;
  logic [3:0]  c_sel;
  logic        pre_en = 1'b0;
  logic [12:0] pre_addr;
  logic [31:0] pre_data;
  logic [29:0] ce_log [$];

  always #5 clk = ~clk;

  soc_sram_sp_arbiter #(
    .AW(32), .DW(32), .MEM_SIZE_BYTE(32768), .PORTS(P)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .sram_ce(sram_ce), .sram_we(sram_we),
    .sram_oe(sram_oe), .sram_waddr(sram_waddr),
    .sram_din(sram_din), .sram_sel(sram_sel),
    .sram_dout(sram_dout)
  );

  // Capture SRAM strobes mid-cycle, away from the edge.
  always @(negedge clk) begin
    c_ce   <= sram_ce;
    c_we   <= sram_we;
    c_oe   <= sram_oe;
    c_addr <= sram_waddr[12:0];
    c_din  <= sram_din;
    c_sel  <= sram_sel;
    if (sram_ce) ce_log.push_back(sram_waddr);
  end

  // SRAM macro model: 1-cycle read latency.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (c_ce && c_we)
      for (int b = 0; b < 4; b++)
        if (c_sel[b]) mem[c_addr][8*b+:8] <= c_din[8*b+:8];
    if (c_ce && c_oe) sram_dout <= mem[c_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = '0; wb_cyc_i = '0; wb_stb_i = '0;
    wb_cti_i = '0; wb_bte_i = '0;
  endtask

  task automatic drive(input int p, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input logic [2:0] cti,
                       input logic [1:0] bte);
    wb_adr_i[p] = adr; wb_dat_i[p] = dat; wb_sel_i[p] = sel;
    wb_we_i[p] = we; wb_cti_i[p] = cti; wb_bte_i[p] = bte;
    wb_cyc_i[p] = 1'b1; wb_stb_i[p] = 1'b1;
  endtask

  task automatic release_port(input int p);
    wb_cyc_i[p] = 1'b0; wb_stb_i[p] = 1'b0; wb_we_i[p] = 1'b0;
  endtask

  // Master sees termination, drops cyc, FSM returns to IDLE.
  task automatic finish_cycle(input int p);
    tick();
    release_port(p);
    #1;
    tick();
  endtask

  task automatic preload(input int a, input logic [31:0] d);
    pre_addr = 13'(a); pre_data = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    tests++;
    if ({wb_ack_o, wb_err_o} !== 4'b0) begin
      fails++; $display("FAIL reset_term: ack/err=%b%b want 0000", wb_ack_o, wb_err_o);
    end
    tests++;
    if ({sram_ce, sram_we, sram_oe} !== 3'b000) begin
      fails++; $display("FAIL reset_en: ce/we/oe=%b%b%b want 000", sram_ce, sram_we, sram_oe);
    end
    tests++;
    if (sram_waddr !== '0 || sram_din !== '0 || sram_sel !== '0) begin
      fails++; $display("FAIL reset_bus: waddr=%h din=%h sel=%h want 0", sram_waddr, sram_din, sram_sel);
    end
    tests++;
    if (dut.state_q !== ST_IDLE || dut.rr_last_q !== 1'b1 || dut.grant_q !== 1'b0) begin
      fails++; $display("FAIL reset_state: st=%0d rr=%0d g=%0d want 0 1 0", dut.state_q, dut.rr_last_q, dut.grant_q);
    end
  endtask

  task automatic test_classic_write_read();
    drive(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, CTI_CLASSIC, BTE_LINEAR);
    #1;
    tests++;
    if (sram_ce !== 1'b0) begin
      fails++; $display("FAIL wr_idle_ce: ce=%b want 0", sram_ce);
    end
    tick();
    tests++;
    if ({sram_ce, sram_we, sram_oe} !== 3'b110 || sram_waddr !== 30'd4
        || sram_din !== 32'hDEADBEEF || sram_sel !== 4'hF) begin
      fails++; $display("FAIL wr_access: ce/we/oe=%b%b%b waddr=%0d din=%h sel=%h want 110 4 deadbeef f",
                        sram_ce, sram_we, sram_oe, sram_waddr, sram_din, sram_sel);
    end
    tick();
    tests++;
    if (wb_ack_o !== 2'b01 || wb_err_o !== 2'b00) begin
      fails++; $display("FAIL wr_ack: ack=%b err=%b want 01 00", wb_ack_o, wb_err_o);
    end
    finish_cycle(0);
    drive(0, 32'h10, 32'h0, 4'hF, 1'b0, CTI_CLASSIC, BTE_LINEAR);
    #1;
    tick();
    tests++;
    if ({sram_ce, sram_we, sram_oe} !== 3'b101 || sram_waddr !== 30'd4) begin
      fails++; $display("FAIL rd_access: ce/we/oe=%b%b%b waddr=%0d want 101 4", sram_ce, sram_we, sram_oe, sram_waddr);
    end
    tick();
    tests++;
    if (wb_ack_o !== 2'b01 || wb_dat_o[0] !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd_data: ack=%b dat=%h want 01 deadbeef", wb_ack_o, wb_dat_o[0]);
    end
    finish_cycle(0);
  endtask

  task automatic test_byte_write();
    drive(0, 32'h10, 32'h000000AA, 4'h1, 1'b1, CTI_CLASSIC, BTE_LINEAR);
    #1;
    tick();
    tests++;
    if (sram_sel !== 4'h1 || sram_we !== 1'b1) begin
      fails++; $display("FAIL byte_sel: sel=%h we=%b want 1 1", sram_sel, sram_we);
    end
    tick();
    finish_cycle(0);
    drive(0, 32'h10, 32'h0, 4'hF, 1'b0, CTI_CLASSIC, BTE_LINEAR);
    #1;
    tick();
    tick();
    tests++;
    if (wb_ack_o !== 2'b01 || wb_dat_o[0] !== 32'hDEADBEAA) begin
      fails++; $display("FAIL byte_merge: ack=%b dat=%h want 01 deadbeaa", wb_ack_o, wb_dat_o[0]);
    end
    finish_cycle(0);
  endtask

  task automatic test_back_to_back();
    drive(0, 32'h20, 32'h11223344, 4'hF, 1'b1, CTI_CLASSIC, BTE_LINEAR);
    #1;
    tick();
    tick();
    tests++;
    if (wb_ack_o !== 2'b01) begin
      fails++; $display("FAIL b2b_ack1: ack=%b want 01", wb_ack_o);
    end
    tick();
    drive(0, 32'h20, 32'h0, 4'hF, 1'b0, CTI_CLASSIC, BTE_LINEAR);
    #1;
    tests++;
    if (wb_ack_o !== 2'b00 || sram_ce !== 1'b1 || sram_oe !== 1'b1 || sram_waddr !== 30'd8) begin
      fails++; $display("FAIL b2b_gap: ack=%b ce=%b oe=%b waddr=%0d want 00 1 1 8",
                        wb_ack_o, sram_ce, sram_oe, sram_waddr);
    end
    tick();
    tests++;
    if (wb_ack_o !== 2'b01 || wb_dat_o[0] !== 32'h11223344) begin
      fails++; $display("FAIL b2b_ack2: ack=%b dat=%h want 01 11223344", wb_ack_o, wb_dat_o[0]);
    end
    finish_cycle(0);
  endtask

  task automatic test_round_robin();
    int order [$];
    logic [P-1:0] prev;
    logic bad;
    rst = 1'b1;
    idle_bus();
    repeat (2) tick();
    rst = 1'b0;
    drive(0, 32'h0, 32'h0, 4'hF, 1'b0, CTI_CLASSIC, BTE_LINEAR);
    drive(1, 32'h4, 32'h0, 4'hF, 1'b0, CTI_CLASSIC, BTE_LINEAR);
    prev = '0;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int p = 0; p < P; p++) begin
        if (prev[p]) begin
          wb_cyc_i[p] = 1'b0; wb_stb_i[p] = 1'b0;
        end else if (!wb_cyc_i[p]) begin
          wb_cyc_i[p] = 1'b1; wb_stb_i[p] = 1'b1;
        end
      end
      #1;
      if (wb_ack_o === 2'b11 || wb_err_o !== 2'b00) bad = 1'b1;
      for (int p = 0; p < P; p++)
        if (wb_ack_o[p]) order.push_back(p);
      prev = wb_ack_o;
    end
    tests++;
    if (bad) begin
      fails++; $display("FAIL rr_exclusive: overlapping ack or stray err seen, want none");
    end
    tests++;
    if (order.size() < 6) begin
      fails++; $display("FAIL rr_count: acks=%0d want >=6", order.size());
    end
    for (int i = 0; i < 6 && i < order.size(); i++) begin
      tests++;
      if (order[i] !== i % 2) begin
        fails++; $display("FAIL rr_order[%0d]: port=%0d want %0d", i, order[i], i % 2);
      end
    end
    idle_bus();
    repeat (3) tick();
  endtask

  task automatic test_wrap_burst();
    int exp_a [4] = '{6, 7, 4, 5};
    for (int i = 4; i < 8; i++) preload(i, 32'hA0000000 | 32'(i));
    ce_log.delete();
    drive(1, 32'h18, 32'h0, 4'hF, 1'b0, CTI_INCR, BTE_WRAP4);
    #1;
    tick();
    tests++;
    if (sram_ce !== 1'b1 || sram_oe !== 1'b1 || sram_waddr !== 30'd6) begin
      fails++; $display("FAIL wrap_first: ce=%b oe=%b waddr=%0d want 1 1 6", sram_ce, sram_oe, sram_waddr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (wb_ack_o !== 2'b10 || wb_dat_o[1] !== (32'hA0000000 | 32'(exp_a[k]))
          || sram_ce !== 1'b1 || sram_waddr !== 30'(exp_a[k+1])) begin
        fails++; $display("FAIL wrap_beat%0d: ack=%b dat=%h ce=%b waddr=%0d want 10 %h 1 %0d",
                          k, wb_ack_o, wb_dat_o[1], sram_ce, sram_waddr,
                          32'hA0000000 | 32'(exp_a[k]), exp_a[k+1]);
      end
    end
    tick();
    wb_cti_i[1] = CTI_EOB;
    #1;
    tests++;
    if (wb_ack_o !== 2'b10 || wb_dat_o[1] !== 32'hA0000005 || sram_ce !== 1'b0) begin
      fails++; $display("FAIL wrap_last: ack=%b dat=%h ce=%b want 10 a0000005 0", wb_ack_o, wb_dat_o[1], sram_ce);
    end
    tick();
    release_port(1);
    #1;
    tests++;
    if (wb_ack_o !== 2'b00) begin
      fails++; $display("FAIL wrap_extra_ack: ack=%b want 00", wb_ack_o);
    end
    tick();
    tests++;
    if (ce_log.size() != 4) begin
      fails++; $display("FAIL wrap_reads: count=%0d want 4", ce_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests++;
        if (ce_log[k] !== 30'(exp_a[k])) begin
          fails++; $display("FAIL wrap_addr[%0d]: waddr=%0d want %0d", k, ce_log[k], exp_a[k]);
        end
      end
    end
  endtask

  task automatic test_error();
    ce_log.delete();
    drive(0, 32'h8000, 32'h12345678, 4'hF, 1'b1, CTI_CLASSIC, BTE_LINEAR);
    #1;
    tick();
    tests++;
    if (sram_ce !== 1'b0 || sram_we !== 1'b0) begin
      fails++; $display("FAIL oor_ce: ce=%b we=%b want 0 0", sram_ce, sram_we);
    end
    tick();
    tests++;
    if (wb_err_o !== 2'b01 || wb_ack_o !== 2'b00) begin
      fails++; $display("FAIL oor_err: err=%b ack=%b want 01 00", wb_err_o, wb_ack_o);
    end
    finish_cycle(0);
    tests++;
    if (ce_log.size() != 0) begin
      fails++; $display("FAIL oor_side_effect: ce_count=%0d want 0", ce_log.size());
    end
    preload(8191, 32'hCAFEF00D);
    ce_log.delete();
    drive(0, 32'h7FFC, 32'h0, 4'hF, 1'b0, CTI_INCR, BTE_LINEAR);
    #1;
    tick();
    tests++;
    if (sram_ce !== 1'b1 || sram_waddr !== 30'd8191) begin
      fails++; $display("FAIL edge_first: ce=%b waddr=%0d want 1 8191", sram_ce, sram_waddr);
    end
    tick();
    tests++;
    if (wb_ack_o !== 2'b01 || wb_err_o !== 2'b00 || wb_dat_o[0] !== 32'hCAFEF00D || sram_ce !== 1'b0) begin
      fails++; $display("FAIL edge_beat0: ack=%b err=%b dat=%h ce=%b want 01 00 cafef00d 0",
                        wb_ack_o, wb_err_o, wb_dat_o[0], sram_ce);
    end
    tick();
    wb_cti_i[0] = CTI_EOB;
    #1;
    tests++;
    if (wb_err_o !== 2'b01 || wb_ack_o !== 2'b00) begin
      fails++; $display("FAIL edge_beat1: err=%b ack=%b want 01 00", wb_err_o, wb_ack_o);
    end
    finish_cycle(0);
    tests++;
    if (ce_log.size() != 1) begin
      fails++; $display("FAIL edge_reads: ce_count=%0d want 1", ce_log.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    drive(1, 32'h18, 32'h0, 4'hF, 1'b0, CTI_INCR, BTE_WRAP4);
    #1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    tick();
    tests++;
    if ({wb_ack_o, wb_err_o, sram_ce, sram_we, sram_oe} !== 7'b0
        || sram_waddr !== '0 || sram_din !== '0 || sram_sel !== '0) begin
      fails++; $display("FAIL rst_mid_out: ack=%b err=%b ce=%b waddr=%0d want all 0",
                        wb_ack_o, wb_err_o, sram_ce, sram_waddr);
    end
    tests++;
    if (dut.state_q !== ST_IDLE) begin
      fails++; $display("FAIL rst_mid_state: st=%0d want 0", dut.state_q);
    end
    rst = 1'b0;
    drive(0, 32'h10, 32'h0, 4'hF, 1'b0, CTI_CLASSIC, BTE_LINEAR);
    drive(1, 32'h18, 32'h0, 4'hF, 1'b0, CTI_CLASSIC, BTE_LINEAR);
    #1;
    tick();
    tests++;
    if (sram_ce !== 1'b1 || sram_waddr !== 30'd4) begin
      fails++; $display("FAIL rst_first_port: ce=%b waddr=%0d want 1 4", sram_ce, sram_waddr);
    end
    tick();
    tests++;
    if (wb_ack_o !== 2'b01 || wb_dat_o[0] !== 32'hA0000004) begin
      fails++; $display("FAIL rst_first_ack: ack=%b dat=%h want 01 a0000004", wb_ack_o, wb_dat_o[0]);
    end
    idle_bus();
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_bus();
    test_reset();
    test_classic_write_read();
    test_byte_write();
    test_back_to_back();
    test_round_robin();
    test_wrap_burst();
    test_error();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
